// File: rtl/intpol2_d4_ctrl_fsm_pkg.sv
// Shared types and constants for the x4 quadratic interpolator control path.
package intpol2_d4_ctrl_fsm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_M,
        WAIT_IN,
        READ,
        PIPE,
        WRITE,
        DONE
    } state_t;

    localparam int unsigned INTPOL_FACTOR = 4;
    localparam int unsigned PHASE_W       = 2;
    localparam int unsigned LAT_W         = 4;

    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(INTPOL_FACTOR - 1);

endpackage

// File: rtl/intpol2_d4_ctrl_fsm_lat_cnt.sv
// Loadable down-counter with zero flag; times the datapath latency after each FIFO pop.
module intpol2_d4_ctrl_fsm_lat_cnt
    import intpol2_d4_ctrl_fsm_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    input  logic             dec,
    output logic [LAT_W-1:0] cnt,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - LAT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/intpol2_d4_ctrl_fsm.sv
// Control FSM for the quadratic x4 interpolator: loads 3 coefficients, then per
// input sample pops one FIFO word, waits out the datapath and writes 4 outputs.
module intpol2_d4_ctrl_fsm
    import intpol2_d4_ctrl_fsm_pkg::*;
#(
    parameter int unsigned CONFIG_WIDTH = 32,
    parameter int unsigned PIPE_LAT     = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clear,
    input  logic                    start,
    input  logic [CONFIG_WIDTH-1:0] ilen,
    input  logic                    Empty,
    input  logic                    Afull,
    input  logic                    comp_addr,
    input  logic                    comp_cnt,
    output logic                    busy,
    output logic                    done,
    output logic                    en_M_addr,
    output logic                    Read_Enable,
    output logic                    en_sum,
    output logic                    Write_Enable,
    output logic [PHASE_W-1:0]      phase
);

    state_t           state;
    logic [LAT_W-1:0] lat_cnt;
    logic             lat_zero;
    logic             lat_last;

    intpol2_d4_ctrl_fsm_lat_cnt u_lat_cnt (
        .clk      (clk),
        .rstn     (rstn),
        .clear    (clear),
        .load     (state == READ),
        .load_val (LAT_W'(PIPE_LAT - 1)),
        .dec      (state == PIPE),
        .cnt      (lat_cnt),
        .zero     (lat_zero)
    );

    // Leave PIPE on the cycle the count hits zero, so the first write lands
    // PIPE_LAT cycles after the pop (PIPE is always visited once).
    assign lat_last = lat_zero || (lat_cnt == LAT_W'(1));

    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            state       <= IDLE;
            phase       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            Read_Enable <= 1'b0;
        end else begin
            done        <= 1'b0;
            Read_Enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (ilen == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= LOAD_M;
                        end
                    end
                end
                LOAD_M: begin
                    if (comp_addr) state <= WAIT_IN;
                end
                WAIT_IN: begin
                    if (!Empty) begin
                        state       <= READ;
                        Read_Enable <= 1'b1;
                    end
                end
                READ: begin
                    state <= PIPE;
                end
                PIPE: begin
                    if (lat_last) state <= WRITE;
                end
                WRITE: begin
                    if (!Afull) begin
                        if (comp_cnt) begin
                            state <= DONE;
                            done  <= 1'b1;
                            phase <= '0;
                        end else if (phase == PHASE_LAST) begin
                            state <= WAIT_IN;
                            phase <= '0;
                        end else begin
                            phase <= phase + PHASE_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Strobes that must react to same-cycle backpressure are gated by the input.
    assign en_M_addr    = (state == LOAD_M) && !comp_addr;
    assign Write_Enable = (state == WRITE) && !Afull;
    assign en_sum       = Write_Enable;

endmodule

// File: tb/tb_intpol2_d4_ctrl_fsm.sv
// Self-checking bench for intpol2_d4_ctrl_fsm with a downstream address/count model.
module tb_intpol2_d4_ctrl_fsm;

    localparam int unsigned CW  = 32;
    localparam int unsigned LAT = 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          clear = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] ilen = '0;
    logic          Afull = 1'b0;
    logic          hold_empty = 1'b0;
    logic          Empty, comp_addr, comp_cnt;
    logic          busy, done, en_M_addr, Read_Enable, en_sum, Write_Enable;
    logic [1:0]    phase;

    always #5 clk = ~clk;

    intpol2_d4_ctrl_fsm #(
        .CONFIG_WIDTH (CW),
        .PIPE_LAT     (LAT)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .clear        (clear),
        .start        (start),
        .ilen         (ilen),
        .Empty        (Empty),
        .Afull        (Afull),
        .comp_addr    (comp_addr),
        .comp_cnt     (comp_cnt),
        .busy         (busy),
        .done         (done),
        .en_M_addr    (en_M_addr),
        .Read_Enable  (Read_Enable),
        .en_sum       (en_sum),
        .Write_Enable (Write_Enable),
        .phase        (phase)
    );

    // Downstream environment: M address counter, output counter, input FIFO level.
    int unsigned fifo_pushes = 0;
    int unsigned fifo_pops   = 0;
    int unsigned m_addr      = 0;
    int unsigned out_cnt     = 0;

    assign Empty     = hold_empty || (fifo_pushes == fifo_pops);
    assign comp_addr = (m_addr == 3);
    assign comp_cnt  = (out_cnt == ilen - 1);

    always @(posedge clk) begin
        if (!rstn || clear || done) begin
            m_addr  <= 0;
            out_cnt <= 0;
        end else begin
            if (en_M_addr) m_addr <= m_addr + 1;
            if (en_sum) out_cnt <= out_cnt + 1;
        end
        if (!rstn || clear) fifo_pops <= fifo_pushes;
        else if (Read_Enable) fifo_pops <= fifo_pops + 1;
    end

    // Event log: kind 0=en_M_addr, 1=read, 2=write, 3=done
    typedef struct {
        int unsigned cyc;
        int          kind;
        int          ph;
    } ev_t;

    ev_t         log_q[$];
    int unsigned cyc  = 0;
    int          viol = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rstn) begin
            int v;
            v = 0;
            if (en_M_addr) log_q.push_back('{cyc, 0, 0});
            if (Read_Enable) log_q.push_back('{cyc, 1, 0});
            if (Write_Enable) log_q.push_back('{cyc, 2, int'(phase)});
            if (done) log_q.push_back('{cyc, 3, 0});
            if (Read_Enable && Write_Enable) v++;
            if (en_sum != Write_Enable) v++;
            if (!busy && (en_M_addr || Read_Enable || Write_Enable || done)) v++;
            viol <= viol + v;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int count_kind(input int unsigned base, input int kind);
        int n = 0;
        for (int unsigned i = base; i < log_q.size(); i++)
            if (log_q[i].kind == kind) n++;
        return n;
    endfunction

    // Reference: 3 coefficient loads, then per input sample one pop followed by
    // up to 4 writes with phases 0..3, truncated at len outputs, then one done.
    int exp_k[$];
    int exp_p[$];

    task automatic ref_build(input int unsigned len);
        exp_k.delete();
        exp_p.delete();
        if (len != 0) begin
            repeat (3) begin exp_k.push_back(0); exp_p.push_back(0); end
            for (int unsigned s = 0; s * 4 < len; s++) begin
                exp_k.push_back(1); exp_p.push_back(0);
                for (int unsigned p = 0; p < 4 && s * 4 + p < len; p++) begin
                    exp_k.push_back(2); exp_p.push_back(int'(p));
                end
            end
        end
        exp_k.push_back(3); exp_p.push_back(0);
    endtask

    int stall_bad, stall_seen, hold_bad, hold_seen;

    task automatic run(input int unsigned len, input bit rnd, input int afull_wr,
                       input int afull_cyc, input int empty_cyc,
                       output int unsigned base, output int unsigned scyc, output bit ok);
        bit stall_done, hold_done;
        stall_bad = 0; stall_seen = 0; hold_bad = 0; hold_seen = 0;
        stall_done = 0; hold_done = 0;
        ilen = len;
        fifo_pushes = fifo_pushes + (len + 3) / 4;
        base = log_q.size();
        scyc = cyc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        ok = 0;
        for (int k = 0; k < 3000; k++) begin
            if (done) begin ok = 1; break; end
            if (!stall_done && afull_wr >= 0 && count_kind(base, 2) == afull_wr &&
                busy && phase == (afull_wr % 4)) begin
                stall_done = 1;
                for (int i = 0; i < afull_cyc; i++) begin
                    Afull = 1'b1;
                    #1;
                    if (Write_Enable || en_sum || Read_Enable || phase != (afull_wr % 4)) stall_bad++;
                    stall_seen++;
                    @(posedge clk); #1;
                end
                Afull = 1'b0;
                continue;
            end
            if (!hold_done && empty_cyc > 0 && count_kind(base, 1) == 1) begin
                hold_done = 1;
                for (int i = 0; i < empty_cyc; i++) begin
                    hold_empty = 1'b1;
                    #1;
                    if (Read_Enable) hold_bad++;
                    hold_seen++;
                    @(posedge clk); #1;
                end
                hold_empty = 1'b0;
                continue;
            end
            if (rnd) begin
                Afull      = ($urandom_range(0, 3) == 0);
                hold_empty = ($urandom_range(0, 4) == 0);
                start      = ($urandom_range(0, 3) == 0);
            end
            @(posedge clk); #1;
        end
        Afull = 1'b0;
        hold_empty = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_after_run", busy, 0);
    endtask

    task automatic check_events(input string name, input int unsigned base, input int unsigned len,
                                input int unsigned scyc, input bit timing);
        int mism, n_obs, n_max, bad;
        int unsigned lw_c, d_c;
        ref_build(len);
        n_obs = log_q.size() - base;
        n_max = (n_obs > exp_k.size()) ? n_obs : exp_k.size();
        mism = 0;
        lw_c = 0;
        d_c = 0;
        for (int i = 0; i < n_max; i++) begin
            if (i >= n_obs || i >= exp_k.size()) mism++;
            else if (log_q[base + i].kind != exp_k[i] ||
                     (exp_k[i] == 2 && log_q[base + i].ph != exp_p[i])) mism++;
        end
        check({name, "_sequence"}, mism, 0);
        for (int i = 0; i < n_obs; i++) begin
            if (log_q[base + i].kind == 2) lw_c = log_q[base + i].cyc;
            if (log_q[base + i].kind == 3) d_c = log_q[base + i].cyc;
        end
        if (len > 0) check({name, "_done_after_last_write"}, longint'(d_c) - longint'(lw_c), 1);
        else check({name, "_done_cycle"}, longint'(d_c) - longint'(scyc), 1);
        if (timing) begin
            bad = 0;
            for (int i = 0; i < n_obs; i++) begin
                if (log_q[base + i].kind == 1) begin
                    if (i + 1 >= n_obs || log_q[base + i + 1].kind != 2 ||
                        log_q[base + i + 1].cyc != log_q[base + i].cyc + LAT) bad++;
                end
                if (i < 3 && len > 0 && log_q[base + i].cyc != scyc + 1 + i) bad++;
            end
            check({name, "_timing"}, bad, 0);
        end
    endtask

    typedef struct {
        int unsigned len;
        int          afull_wr;
        int          afull_cyc;
        int          empty_cyc;
        int          e_maddr;
        int          e_rd;
        int          e_wr;
        int          e_last_ph;
        int          e_done;
    } vec_t;

    initial begin
        vec_t        vecs[8];
        int unsigned base, scyc;
        bit          ok;
        int          lp;

        vecs[0] = '{8, -1, 0, 0, 3, 2, 8, 3, 1};
        vecs[1] = '{6, -1, 0, 0, 3, 2, 6, 1, 1};
        vecs[2] = '{8, 2, 5, 0, 3, 2, 8, 3, 1};
        vecs[3] = '{8, -1, 0, 10, 3, 2, 8, 3, 1};
        vecs[4] = '{0, -1, 0, 0, 0, 0, 0, -1, 1};
        vecs[5] = '{4, -1, 0, 0, 3, 1, 4, 3, 1};
        vecs[6] = '{1, -1, 0, 0, 3, 1, 1, 0, 1};
        vecs[7] = '{5, -1, 0, 0, 3, 2, 5, 0, 1};

        // Reset held with start asserted
        rstn = 1'b0;
        start = 1'b1;
        ilen = 8;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {busy, done, en_M_addr, Read_Enable, Write_Enable, en_sum, phase}, 0);
        rstn = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        check("idle_after_reset", busy, 0);

        for (int v = 0; v < 8; v++) begin
            string nm;
            nm = $sformatf("vec%0d", v);
            run(vecs[v].len, 1'b0, vecs[v].afull_wr, vecs[v].afull_cyc, vecs[v].empty_cyc, base, scyc, ok);
            check({nm, "_completes"}, ok, 1);
            check({nm, "_maddr"}, count_kind(base, 0), vecs[v].e_maddr);
            check({nm, "_reads"}, count_kind(base, 1), vecs[v].e_rd);
            check({nm, "_writes"}, count_kind(base, 2), vecs[v].e_wr);
            check({nm, "_dones"}, count_kind(base, 3), vecs[v].e_done);
            if (vecs[v].e_last_ph >= 0) begin
                lp = -1;
                for (int unsigned i = base; i < log_q.size(); i++)
                    if (log_q[i].kind == 2) lp = log_q[i].ph;
                check({nm, "_last_phase"}, lp, vecs[v].e_last_ph);
            end
            if (vecs[v].afull_cyc > 0) begin
                check({nm, "_stall_cycles"}, stall_seen, vecs[v].afull_cyc);
                check({nm, "_stall_quiet"}, stall_bad, 0);
            end
            if (vecs[v].empty_cyc > 0) begin
                int unsigned r0, r1;
                int nr;
                r0 = 0; r1 = 0; nr = 0;
                for (int unsigned i = base; i < log_q.size(); i++)
                    if (log_q[i].kind == 1) begin
                        if (nr == 0) r0 = log_q[i].cyc;
                        else r1 = log_q[i].cyc;
                        nr++;
                    end
                check({nm, "_empty_hold_cycles"}, hold_seen, vecs[v].empty_cyc);
                check({nm, "_empty_no_read"}, hold_bad, 0);
                check({nm, "_empty_read_gap_ok"}, (r1 > r0 + vecs[v].empty_cyc) ? 1 : 0, 1);
            end
            check_events(nm, base, vecs[v].len, scyc, 1'b1);
        end

        // clear during the third write of a run
        fifo_pushes = fifo_pushes + 2;
        ilen = 8;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 100 && phase != 2; k++) begin
            @(posedge clk); #1;
        end
        check("clear_reached_phase2", phase, 2);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("clear_outputs", {busy, done, en_M_addr, Read_Enable, Write_Enable, en_sum, phase}, 0);
        @(posedge clk); #1;
        check("clear_stays_idle", busy, 0);
        run(4, 1'b0, -1, 0, 0, base, scyc, ok);
        check("after_clear_completes", ok, 1);
        check("after_clear_writes", count_kind(base, 2), 4);
        check_events("after_clear", base, 4, scyc, 1'b1);

        // Randomized runs with random backpressure, FIFO starvation and stray starts
        for (int r = 0; r < 25; r++) begin
            int unsigned len;
            len = $urandom_range(0, 20);
            run(len, 1'b1, -1, 0, 0, base, scyc, ok);
            check($sformatf("rand%0d_completes", r), ok, 1);
            check_events($sformatf("rand%0d_len%0d", r, len), base, len, scyc, 1'b0);
        end

        check("invariants", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
